// File: rtl/sync_updown_counter_pkg.sv
// sync_updown_counter_pkg: default sizing and elaboration-time parameter check for the modulo-N counter
package sync_updown_counter_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_MODULUS = 10;
  function automatic bit modulus_ok(input int width, input longint modulus);
    return modulus >= 2 && modulus <= (longint'(1) << width);
  endfunction
endpackage

// File: rtl/sync_updown_counter_if.sv
// sync_updown_counter_if: control and count bundle between a counter stage and its driver
interface sync_updown_counter_if #(parameter int WIDTH = 4);
  logic en;
  logic up;
  logic load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic tc;
  logic wrapped;
  modport master (output en, up, load, load_val, input q, tc, wrapped);
  modport slave (input en, up, load, load_val, output q, tc, wrapped);
endinterface

// File: rtl/sync_updown_counter_t_ff_clr.sv
// t_ff_clr: T flip-flop with asynchronous active-low clear
module t_ff_clr (
  input  logic clk,
  input  logic clear_n,
  input  logic t,
  output logic q
);
  always_ff @(posedge clk or negedge clear_n)
    if (!clear_n) q <= 1'b0;
    else if (t) q <= ~q;
endmodule

// File: rtl/sync_updown_counter.sv
// sync_updown_counter: modulo-MODULUS up/down counter on T cells with load, tc and wrap pulse; COUNTER_SAT_EN selects saturating mode
module sync_updown_counter
  import sync_updown_counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int MODULUS = DEF_MODULUS
) (
  input logic clk,
  input logic clear_n,
  sync_updown_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  logic [WIDTH-1:0] q, next_q, t, hi_next, lo_next, clamp;
  logic hit, wrap_next;
  if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_params
    $error("sync_updown_counter: MODULUS must lie in 2..2**WIDTH");
  end
`ifdef COUNTER_SAT_EN
  assign hi_next = MAX;
  assign lo_next = '0;
  assign wrap_next = 1'b0;
`else
  assign hi_next = '0;
  assign lo_next = MAX;
  assign wrap_next = hit;
`endif
  always_comb begin
    hit = bus.en & ~bus.load & (bus.up ? q == MAX : q == '0);
    clamp = ({1'b0, bus.load_val} < (WIDTH+1)'(MODULUS)) ? bus.load_val : MAX;
    next_q = bus.load ? clamp :
             !bus.en ? q :
             bus.up ? (q == MAX ? hi_next : q + 1'b1) :
             (q == '0 ? lo_next : q - 1'b1);
    t = q ^ next_q;
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    t_ff_clr u_t (.clk(clk), .clear_n(clear_n), .t(t[i]), .q(q[i]));
  end
  always_ff @(posedge clk or negedge clear_n)
    if (!clear_n) bus.wrapped <= 1'b0;
    else bus.wrapped <= wrap_next;
  assign bus.q = q;
  assign bus.tc = clear_n & hit;
endmodule

// File: tb/tb_sync_updown_counter.sv
// tb_sync_updown_counter: directed and random checks of one counter plus a two-digit cascade against an arithmetic model
module tb_sync_updown_counter;
  localparam int M = 10;
  logic clk = 1'b0;
  logic clear_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int mq, uq, tq;
  bit mw, uw, tw, ut;

  always #5 clk = ~clk;

  sync_updown_counter_if #(.WIDTH(4)) d ();
  sync_updown_counter_if #(.WIDTH(4)) cu ();
  sync_updown_counter_if #(.WIDTH(4)) ct ();
  assign ct.en = cu.tc;

  sync_updown_counter #(.WIDTH(4), .MODULUS(M)) dut (.clk(clk), .clear_n(clear_n), .bus(d));
  sync_updown_counter #(.WIDTH(4), .MODULUS(M)) units (.clk(clk), .clear_n(clear_n), .bus(cu));
  sync_updown_counter #(.WIDTH(4), .MODULUS(M)) tens (.clk(clk), .clear_n(clear_n), .bus(ct));

  function automatic bit at_end(input int q, input bit u);
    return u ? q == M - 1 : q == 0;
  endfunction

  function automatic bit tc_of(input int q, input bit e, input bit u, input bit l);
    return e && !l && at_end(q, u);
  endfunction

  function automatic int next_of(input int q, input bit e, input bit u, input bit l, input int lv);
    if (l) return lv < M ? lv : M - 1;
    if (!e) return q;
`ifdef COUNTER_SAT_EN
    if (at_end(q, u)) return q;
`endif
    return u ? (q + 1) % M : (q + M - 1) % M;
  endfunction

  function automatic bit wrap_of(input int q, input bit e, input bit u, input bit l);
`ifdef COUNTER_SAT_EN
    return 1'b0;
`else
    return tc_of(q, e, u, l);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit e, input bit u, input bit l, input int lv);
    logic [31:0] v;
    v = lv;
    d.en = e;
    d.up = u;
    d.load = l;
    d.load_val = v[3:0];
    #1;
    check("tc", 32'(d.tc), 32'(tc_of(mq, e, u, l)));
    @(posedge clk);
    mw = wrap_of(mq, e, u, l);
    mq = next_of(mq, e, u, l, lv);
    @(negedge clk);
    check("q", 32'(d.q), 32'(mq));
    check("wrapped", 32'(d.wrapped), 32'(mw));
  endtask

  initial begin
    d.en = 1'b1; d.up = 1'b0; d.load = 1'b0; d.load_val = '0;
    cu.en = 1'b0; cu.up = 1'b1; cu.load = 1'b0; cu.load_val = '0;
    ct.up = 1'b1; ct.load = 1'b0; ct.load_val = '0;
    mq = 0; mw = 0;
    #3;
    check("reset_q", 32'(d.q), 0);
    check("reset_wrapped", 32'(d.wrapped), 0);
    check("reset_tc_gated", 32'(d.tc), 0);
    @(negedge clk);
    @(negedge clk);
    clear_n = 1'b1;
    // asynchronous clear mid-cycle from q = 7 with a load pending
    step(0, 0, 1, 7);
    d.en = 1'b1; d.up = 1'b1; d.load = 1'b1; d.load_val = 4'd3;
    #2 clear_n = 1'b0;
    #1;
    check("async_clear_q", 32'(d.q), 0);
    check("async_clear_wrapped", 32'(d.wrapped), 0);
    check("async_clear_tc", 32'(d.tc), 0);
    mq = 0; mw = 0;
    @(negedge clk);
    check("load_discarded_q", 32'(d.q), 0);
    clear_n = 1'b1;
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 0, 1, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 1, 5);
    step(1, 1, 1, 13);
    step(1, 1, 0, 0);
    step(1, 0, 1, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)));
    // two-digit cascade: tens advances on the units terminal count
    clear_n = 1'b0;
    cu.en = 1'b1;
    @(negedge clk);
    clear_n = 1'b1;
    uq = 0; tq = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      ut = tc_of(uq, 1, 1, 0);
      tw = wrap_of(tq, ut, 1, 0);
      tq = next_of(tq, ut, 1, 0, 0);
      uw = wrap_of(uq, 1, 1, 0);
      uq = next_of(uq, 1, 1, 0, 0);
      @(negedge clk);
      check("units_q", 32'(cu.q), 32'(uq));
      check("tens_q", 32'(ct.q), 32'(tq));
      check("units_wrapped", 32'(cu.wrapped), 32'(uw));
      check("tens_wrapped", 32'(ct.wrapped), 32'(tw));
`ifndef COUNTER_SAT_EN
      if (k == 99) begin
        check("cascade99_units", 32'(cu.q), 9);
        check("cascade99_tens", 32'(ct.q), 9);
      end
      if (k == 100) begin
        check("cascade100_units", 32'(cu.q), 0);
        check("cascade100_tens", 32'(ct.q), 0);
        check("cascade100_units_wrapped", 32'(cu.wrapped), 1);
        check("cascade100_tens_wrapped", 32'(ct.wrapped), 1);
      end
`endif
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
